// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and its keypad/consumer side.
// The scanner connects through the slave modport; the keypad and key consumer use master.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchronised rows, debounced press/release and hex key output.
// Define KEYPAD_MULTIKEY_REJECT_EN to reject scans and debounces that see more than one row low.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 24000,
    parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
    input  logic            clk,
    input  logic            reset,
    keypad_scanner_if.slave kp
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]        sync1_q, sync2_q;
    logic [3:0]        cols_q, cols_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic [3:0] low;
    logic [1:0] pick;
    logic       row_low;
    logic       capture_ok;
    logic       db_abort;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    assign low     = ~sync2_q;
    assign row_low = low[row_q];
    assign pick    = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    logic multi;
    logic other_low;
    assign multi      = (low & 4'(low - 4'd1)) != 4'd0;
    assign other_low  = |(low & ~(4'b0001 << row_q));
    assign capture_ok = (|low) && !multi;
    assign db_abort   = !row_low || other_low;
`else
    assign capture_ok = |low;
    assign db_abort   = !row_low;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        scan_cnt_d  = scan_cnt_q;
        db_cnt_d    = db_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (capture_ok) begin
                        state_d  = DEBOUNCE;
                        row_d    = pick;
                        db_cnt_d = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            DEBOUNCE: begin
                if (db_abort) begin
                    state_d    = SCAN;
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    db_cnt_d   = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    key_code_d  = key_map(row_q, col_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    db_cnt_d    = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!row_low) begin
                    state_d  = RELEASE;
                    db_cnt_d = '0;
                end
            end
            RELEASE: begin
                // A bounce back low returns to HELD without a new pulse.
                if (row_low) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = SCAN;
                    key_held_d = 1'b0;
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase

        cols_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            scan_cnt_q  <= '0;
            db_cnt_q    <= '0;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            cols_q      <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            scan_cnt_q  <= scan_cnt_d;
            db_cnt_q    <= db_cnt_d;
            sync1_q     <= kp.rows;
            sync2_q     <= sync1_q;
            cols_q      <= cols_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and an expected-key scoreboard.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  force_low = '0;
    logic [3:0]  rows_m;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [3:0] exp_q[$];

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.cols[c]) rows_m[r] = 1'b0;
            end
        end
        rows_m = rows_m & ~force_low;
    end
    assign kp.rows = rows_m;

    always @(posedge clk) if (kp.key_valid) pulses <= pulses + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!kp.key_valid && n < budget) begin
            step(1);
            n++;
        end
        if (!kp.key_valid) begin
            check({tag, "_timeout"}, {31'd0, kp.key_valid}, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, exp_q.size(), 32'd1);
        end else begin
            check(tag, {28'd0, kp.key_code}, {28'd0, exp_q.pop_front()});
            check({tag, "_held"}, {31'd0, kp.key_held}, 32'd1);
            step(1);
            check({tag, "_pulse_width"}, {31'd0, kp.key_valid}, 32'd0);
        end
    endtask

    task automatic wait_cols(input string tag, input logic [3:0] v, input int budget);
        int n = 0;
        while (kp.cols !== v && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {28'd0, kp.cols}, {28'd0, v});
    endtask

    task automatic wait_unheld(input string tag, input int budget);
        int n = 0;
        while (kp.key_held !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {31'd0, kp.key_held}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_cols;

        // Reset state
        step(3);
        check("rst_cols", {28'd0, kp.cols}, 32'hE);
        check("rst_code", {28'd0, kp.key_code}, 32'h0);
        check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("rst_held", {31'd0, kp.key_held}, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_cols = ~(4'b0001 << ((k / 4) % 4));
            check("scan_step", {28'd0, kp.cols}, {28'd0, exp_cols});
        end

        // Key '6' (r1,c2): one pulse, held until debounced release, resume at col3
        exp_q.push_back(4'h6);
        exp_pulses++;
        pressed[1*4+2] = 1'b1;
        wait_valid("key6", 200);
        step(40);
        check("key6_still_held", {31'd0, kp.key_held}, 32'd1);
        check("key6_single_pulse", pulses, exp_pulses);
        pressed = '0;
        step(14);
        check("key6_release_early", {31'd0, kp.key_held}, 32'd1);
        wait_unheld("key6_release", 10);
        check("key6_resume_col3", {28'd0, kp.cols}, 32'h7);
        check("key6_code_kept", {28'd0, kp.key_code}, 32'h6);

        // Short 5-cycle press on row0 at col0: captured, aborted, resume at col1
        wait_cols("sync_col3", 4'b0111, 40);
        wait_cols("sync_col0", 4'b1110, 40);
        force_low = 4'b0001;
        step(5);
        check("short_cols_frozen", {28'd0, kp.cols}, 32'hE);
        force_low = 4'b0000;
        wait_cols("short_resume_col1", 4'b1101, 8);
        check("short_no_pulse", pulses, exp_pulses);
        check("short_code_kept", {28'd0, kp.key_code}, 32'h6);

        // Key 'D' (r3,c3) with a 3-cycle bounce during release
        exp_q.push_back(4'hD);
        exp_pulses++;
        pressed[15] = 1'b1;
        wait_valid("keyD", 200);
        step(10);
        pressed[15] = 1'b0;
        step(6);
        check("glitch_pre", {31'd0, kp.key_held}, 32'd1);
        pressed[15] = 1'b1;
        step(3);
        pressed[15] = 1'b0;
        check("glitch_mid", {31'd0, kp.key_held}, 32'd1);
        step(14);
        check("glitch_release_early", {31'd0, kp.key_held}, 32'd1);
        wait_unheld("glitch_release", 10);
        check("glitch_single_pulse", pulses, exp_pulses);
        check("glitch_resume_col0", {28'd0, kp.cols}, 32'hE);

        // Rows 0 and 2 low together at col0
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        step(200);
        check("multi_rejected", pulses, exp_pulses);
`else
        exp_q.push_back(4'h1);
        exp_pulses++;
        wait_valid("multi_lowest", 200);
        step(20);
        check("multi_single_pulse", pulses, exp_pulses);
`endif
        pressed = '0;
        step(40);
        check("multi_released", {31'd0, kp.key_held}, 32'd0);

        // Reset while HELD on '5' (r1,c1), key kept pressed
        exp_q.push_back(4'h5);
        exp_pulses++;
        pressed[1*4+1] = 1'b1;
        wait_valid("key5", 200);
        step(5);
        reset = 1'b1;
        step(1);
        check("rst_held_held", {31'd0, kp.key_held}, 32'd0);
        check("rst_held_code", {28'd0, kp.key_code}, 32'h0);
        check("rst_held_cols", {28'd0, kp.cols}, 32'hE);
        reset = 1'b0;
        exp_q.push_back(4'h5);
        exp_pulses++;
        wait_valid("key5_reaccept", 200);
        step(30);
        check("key5_pulses", pulses, exp_pulses);
        pressed = '0;
        step(40);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 24000: clk cycles each column is driven during scanning (1 ms at 24 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 480000: consecutive stable cycles required to accept a press or release (20 ms).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rows  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
REQ-006 SHALL have port cols  output  4  keypad column drive, active-low one-hot.
REQ-007 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer; all decisions use synchronized rows (2-cycle pin latency).
REQ-011 SHALL drive all outputs from registers.
REQ-012 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: SHALL drive cols = ~(1<<c), advancing c 0->1->2->3->0 every SCAN_DIV cycles.
REQ-014 SCAN: SHALL sample synchronized rows on the last cycle of each column dwell; any low row captures (row r, column c), enters DEBOUNCE, and holds cols.
REQ-015 Without the macro, multiple low rows in one sample SHALL capture the lowest index r.
REQ-016 DEBOUNCE: SHALL count consecutive cycles with captured row low; row high before DEBOUNCE_CYCLES SHALL return to SCAN at column (c+1) mod 4 with no output change.
REQ-017 On the DEBOUNCE_CYCLES-th consecutive low cycle, SHALL register key_code and assert key_valid for exactly the next cycle, set key_held=1, and enter HELD.
REQ-018 Key map (row r: cols 0..3) SHALL be r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-019 HELD: SHALL keep cols fixed, ignore all other rows and keys, and enter RELEASE on the first cycle the captured row reads high.
REQ-020 RELEASE: captured row low before DEBOUNCE_CYCLES consecutive high cycles SHALL return to HELD with no new key_valid.
REQ-021 RELEASE: after DEBOUNCE_CYCLES consecutive high cycles, SHALL clear key_held, keep key_code, and return to SCAN at column (c+1) mod 4.
REQ-022 SHALL size counters with $clog2 of their parameter; counters SHALL clear on every state change, with no wrap or overflow.
REQ-023 SHALL never assert key_valid twice for one physical press.

Reset
REQ-024 While reset=1, SHALL set on the next clk edge: state SCAN, c=0, cols=4'b1110, key_code=0, key_valid=0, key_held=0, counters=0, synchronizer=4'b1111.
REQ-025 Reset in any state, including mid-DEBOUNCE or HELD, SHALL discard the capture; a still-pressed key SHALL be rescanned and re-debounced from SCAN.

Configuration
REQ-026 Macro KEYPAD_MULTIKEY_REJECT_EN, when defined: a SCAN sample with more than one row low SHALL capture nothing and scanning continues.
REQ-027 Macro KEYPAD_MULTIKEY_REJECT_EN, when defined: in DEBOUNCE, any non-captured row going low SHALL abort to SCAN at column (c+1) mod 4.
REQ-028 Without KEYPAD_MULTIKEY_REJECT_EN, REQ-015 SHALL apply and other rows SHALL be ignored in DEBOUNCE.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=16)
REQ-029 Reset 3 cycles, rows=1111 -> cols=1110, key_code=0, key_valid=0, key_held=0; then cols steps 1110,1101,1011,0111,1110 every 4 cycles.
REQ-030 Hold row1 low while col2 driven, steady -> exactly one key_valid pulse with key_code=6 and key_held=1 until release; release -> key_held=0 after 16 high cycles, scanning resumes at col3.
REQ-031 Row0 low 5 cycles at col0, then high -> no key_valid, key_code unchanged, scanning resumes at col1.
REQ-032 In HELD on key 'D' (r3,c3), release, glitch low 3 cycles inside RELEASE, then high -> key_held stays 1 through the glitch, no second pulse, key_held=0 after 16 clean high cycles.
REQ-033 Rows 0 and 2 low at col0 -> with macro: no key_valid; without macro: one pulse, key_code=1.
REQ-034 Assert reset while HELD on key '5' -> next cycle key_held=0, key_code=0, cols=1110; key still pressed -> re-accepted with one pulse, key_code=5.
